riscv_test_sequencer: RTL
=========================

// Module: riscv_test_sequencer
// PURPOSE
// - Synthesisable successor to the ISA-regression harness: sequences NUM_TESTS riscv-tests images through the core.
// - Per test: request image load, hold core in reset, release it, watch a7/a0/gp taps for the exit ecall.
// - Flags pass/fail/timeout per test, keeps running totals, optionally continues past failures.
// - Sits beside rv32im_vector: drives the core reset; the memory loader answers the load handshake.
// PARAMETERS
// NUM_TESTS      45        number of images; index 0..NUM_TESTS-1
// EXIT_CODE      32'h5d    a7 value signalling test exit (ecall exit)
// DRAIN_CYCLES   50        cycles waited after exit detect before sampling a0 (>=1)
// RST_CYCLES     2         cycles core_rst stays high after load_done (>=1)
// TIMEOUT_CYCLES 100000    max RUN cycles per test before timeout (>=1)
// STOP_ON_FAIL   1         1: halt on first fail/timeout; 0: record and continue
// IDX_W          $clog2(NUM_TESTS+1)  index/counter width (derived localparam)
// PORTS
// clk          in   1      clock
// rst          in   1      asynchronous active-high reset
// start        in   1      1-cycle pulse: begin sequence at test 0
// a7_i         in   32     core x17 tap
// a0_i         in   32     core x10 tap (0 = pass, else fail code)
// gp_i         in   32     core x3 tap (testnum, captured on fail/timeout)
// load_req     out  1      request loader to write image load_idx
// load_idx     out  IDX_W  image index requested / under test
// load_done    in   1      loader finished image load_idx
// core_rst     out  1      active-high reset to core
// busy         out  1      sequence in progress
// done         out  1      sequence finished (level, until next start or rst)
// test_pass    out  1      1-cycle pulse: current test passed
// test_fail    out  1      1-cycle pulse: current test failed (a0!=0)
// test_tmo     out  1      1-cycle pulse: current test timed out
// pass_cnt     out  IDX_W  tests passed this sequence
// fail_cnt     out  IDX_W  tests failed or timed out this sequence
// fail_idx     out  IDX_W  index of first fail/timeout
// fail_a0      out  32     a0 captured at first fail (0 on timeout)
// fail_gp      out  32     gp captured at first fail/timeout
// BEHAVIOUR
// - Reset: state IDLE, core_rst=1, all other outputs and counters 0. core_rst stays 1 whenever not in RELEASE-exit/RUN/DRAIN.
// - IDLE: start -> LOAD, clears counters, fail_* and done; load_idx=0. start while busy is ignored.
// - LOAD: load_req=1, core_rst=1; load_done (may be high on the entry cycle) -> RELEASE, load_req drops next cycle.
// - RELEASE: core_rst=1 for RST_CYCLES cycles, then RUN with core_rst=0 and timeout counter cleared.
// - RUN: counter increments each cycle; a7_i==EXIT_CODE -> DRAIN. counter reaching TIMEOUT_CYCLES -> TMO.
//   Exit detect and timeout in the same cycle: exit wins.
// - DRAIN: core keeps running DRAIN_CYCLES cycles, then samples a0_i/gp_i -> CHECK.
// - CHECK (1 cycle): a0==0 -> test_pass, pass_cnt++; else test_fail, fail_cnt++, capture fail_* if first failure.
// - TMO (1 cycle): test_tmo, fail_cnt++, capture idx/gp (fail_a0=0) if first failure.
// - After CHECK/TMO: core_rst=1. Halt if failed/timed out and STOP_ON_FAIL=1 -> DONE.
//   Else if load_idx==NUM_TESTS-1 -> DONE. Else load_idx++ -> LOAD.
// - DONE: done=1, busy=0, core_rst=1; start -> new sequence. busy=1 in LOAD..TMO.
// - Counters saturate at 2^IDX_W-1; load_idx never wraps.
// - rst mid-sequence: immediate return to reset values; no pulse emitted.
// TESTING
// - 3 tests, load_done 4 cycles after req, exit at 200 cycles, a0=0 -> 3 test_pass pulses, pass_cnt=3, done=1.
// - Test 1 exits with a0=0x7, gp=0x3, STOP_ON_FAIL=1 -> test_fail, fail_idx=1, fail_a0=7, fail_gp=3, done, load_idx=1.
// - STOP_ON_FAIL=0, test 0 fails, test 2 times out -> pass_cnt=1, fail_cnt=2, fail_idx=0.
// - TIMEOUT_CYCLES=10, a7 hits EXIT_CODE on cycle 10 -> DRAIN taken, no test_tmo.
// - load_done high on LOAD entry cycle -> core_rst low exactly RST_CYCLES+1 cycles after LOAD entry.
// - Assert rst during DRAIN -> core_rst=1, busy=0, counters 0 next edge; start restarts at test 0.

Source files
------------

// File: rtl/riscv_test_sequencer.sv
// Sequences riscv-tests images through the core: load, reset, run, watch for the
// exit ecall, then score each test as pass, fail or timeout and keep running totals.
module riscv_test_sequencer #(
   parameter int          NUM_TESTS      = 45,
   parameter logic [31:0] EXIT_CODE      = 32'h5d,
   parameter int          DRAIN_CYCLES   = 50,
   parameter int          RST_CYCLES     = 2,
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter bit          STOP_ON_FAIL   = 1'b1,
   localparam int         IDX_W          = $clog2(NUM_TESTS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      a7_i,
   input  logic [31:0]      a0_i,
   input  logic [31:0]      gp_i,
   output logic             load_req,
   output logic [IDX_W-1:0] load_idx,
   input  logic             load_done,
   output logic             core_rst,
   output logic             busy,
   output logic             done,
   output logic             test_pass,
   output logic             test_fail,
   output logic             test_tmo,
   output logic [IDX_W-1:0] pass_cnt,
   output logic [IDX_W-1:0] fail_cnt,
   output logic [IDX_W-1:0] fail_idx,
   output logic [31:0]      fail_a0,
   output logic [31:0]      fail_gp
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + DRAIN_CYCLES + RST_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_MAX  = '1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DRAIN, S_CHECK, S_TMO, S_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
      return (v == IDX_MAX) ? v : v + IDX_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         load_req  <= 1'b0;
         load_idx  <= '0;
         core_rst  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         test_pass <= 1'b0;
         test_fail <= 1'b0;
         test_tmo  <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
         fail_idx  <= '0;
         fail_a0   <= '0;
         fail_gp   <= '0;
      end else begin
         test_pass <= 1'b0;
         test_fail <= 1'b0;
         test_tmo  <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_LOAD;
                  load_req <= 1'b1;
                  core_rst <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  load_idx <= '0;
                  pass_cnt <= '0;
                  fail_cnt <= '0;
                  fail_idx <= '0;
                  fail_a0  <= '0;
                  fail_gp  <= '0;
               end
            end
            S_LOAD: begin
               if (load_done) begin
                  state    <= S_RELEASE;
                  load_req <= 1'b0;
                  cnt      <= '0;
               end
            end
            S_RELEASE: begin
               if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                  state    <= S_RUN;
                  core_rst <= 1'b0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               // Exit has priority over a timeout landing on the same cycle.
               if (a7_i == EXIT_CODE) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state    <= S_TMO;
                  core_rst <= 1'b1;
                  test_tmo <= 1'b1;
                  fail_cnt <= sat_inc(fail_cnt);
                  if (fail_cnt == '0) begin
                     fail_idx <= load_idx;
                     fail_a0  <= '0;
                     fail_gp  <= gp_i;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                  state    <= S_CHECK;
                  core_rst <= 1'b1;
                  if (a0_i == '0) begin
                     test_pass <= 1'b1;
                     pass_cnt  <= sat_inc(pass_cnt);
                  end else begin
                     test_fail <= 1'b1;
                     fail_cnt  <= sat_inc(fail_cnt);
                     if (fail_cnt == '0) begin
                        fail_idx <= load_idx;
                        fail_a0  <= a0_i;
                        fail_gp  <= gp_i;
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_CHECK, S_TMO: begin
               // test_fail/test_tmo are high exactly during this scoring cycle.
               if ((STOP_ON_FAIL && (test_fail || test_tmo)) || load_idx == LAST_IDX) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= S_LOAD;
                  load_idx <= load_idx + IDX_W'(1);
                  load_req <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
